// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC TX arbiter.
// The IPG state exists only when MAC_TX_ARB_IPG_EN is defined.
package mac_pkg;

  // Minimum inter-packet gap in bytes.
  localparam int unsigned IpgBytes = 12;

  function automatic int unsigned ipg_cyc_default(int unsigned keep_w);
    return IpgBytes / keep_w;
  endfunction

`ifdef MAC_TX_ARB_IPG_EN
  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StIpg
  } tx_arb_state_e;
`else
  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } tx_arb_state_e;
`endif

endpackage

// File: rtl/mac_tx_arb_if.sv
// Source-side and MAC-side beat streams of the TX arbiter, sources packed per DATA_W slot.
interface mac_tx_arb_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned REQ_N  = 2
);
  logic [REQ_N-1:0]        req_valid_i;
  logic [REQ_N*DATA_W-1:0] req_data_i;
  logic [REQ_N*KEEP_W-1:0] req_keep_i;
  logic [REQ_N-1:0]        req_last_i;
  logic [REQ_N-1:0]        req_ready_o;
  logic                    cancel_i;
  logic                    valid_o;
  logic [DATA_W-1:0]       data_o;
  logic [KEEP_W-1:0]       keep_o;
  logic                    last_o;
  logic                    ready_i;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_data_i, req_keep_i, req_last_i, cancel_i, ready_i,
    output req_ready_o, valid_o, data_o, keep_o, last_o
  );

  // Sources plus MAC datapath, i.e. whoever drives the arbiter.
  modport master (
    output req_valid_i, req_data_i, req_keep_i, req_last_i, cancel_i, ready_i,
    input  req_ready_o, valid_o, data_o, keep_o, last_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned REQ_N = 2,
  parameter int unsigned PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
  input  logic [REQ_N-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [REQ_N-1:0] gnt_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      idx = (32'(ptr_i) + i) % REQ_N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arb.sv
// Frame-level round-robin arbiter feeding the MAC TX datapath.
// Optional inter-packet gap state compiled in with MAC_TX_ARB_IPG_EN.
module mac_tx_arb
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned KEEP_W  = DATA_W / 8,
  parameter int unsigned REQ_N   = 2,
  parameter int unsigned IPG_CYC = ipg_cyc_default(KEEP_W)
) (
  input  logic             clk,
  input  logic             reset,
  mac_tx_arb_if.slave      bus,
  output logic [REQ_N-1:0] grant_o,
  output logic             busy_o
);

  localparam int unsigned PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

  tx_arb_state_e    state_q, state_d;
  logic [REQ_N-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [REQ_N-1:0] arb_gnt;
  logic [PTR_W-1:0] arb_idx;
  logic [PTR_W-1:0] ptr_after_g;
  logic             in_xfer;
  logic             frame_end;
  logic             leave_xfer;

`ifdef MAC_TX_ARB_IPG_EN
  localparam int unsigned CNT_W = (IPG_CYC > 0) ? $clog2(IPG_CYC + 1) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Kept so both builds share one parameter list.
  logic unused_ipg_cyc;
  assign unused_ipg_cyc = ^IPG_CYC;
`endif

  rr_arbiter #(
    .REQ_N (REQ_N),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i (bus.req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
      if (arb_gnt[i]) arb_idx = PTR_W'(i);
    end
  end

  assign in_xfer     = (state_q == StXfer);
  assign ptr_after_g = (32'(gidx_q) == REQ_N - 1) ? '0 : gidx_q + 1'b1;

  // Output mux of the granted source; a cancel suppresses the handshake in that cycle.
  always_comb begin
    bus.valid_o     = in_xfer & ~bus.cancel_i & bus.req_valid_i[gidx_q];
    bus.last_o      = in_xfer & bus.req_last_i[gidx_q];
    bus.data_o      = bus.req_data_i[32'(gidx_q) * DATA_W +: DATA_W];
    bus.keep_o      = bus.req_keep_i[32'(gidx_q) * KEEP_W +: KEEP_W];
    bus.req_ready_o = '0;
    if (in_xfer && !bus.cancel_i) bus.req_ready_o = grant_q & {REQ_N{bus.ready_i}};
  end

  assign frame_end  = bus.valid_o & bus.ready_i & bus.last_o;
  assign leave_xfer = frame_end | bus.cancel_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
`ifdef MAC_TX_ARB_IPG_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid_i) begin
          grant_d = arb_gnt;
          gidx_d  = arb_idx;
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (leave_xfer) begin
          grant_d = '0;
          ptr_d   = ptr_after_g;
          state_d = StIdle;
`ifdef MAC_TX_ARB_IPG_EN
          if (IPG_CYC != 0) begin
            state_d = StIpg;
            cnt_d   = CNT_W'(IPG_CYC);
          end
`endif
        end
      end
`ifdef MAC_TX_ARB_IPG_EN
      StIpg: begin
        // cnt_q runs IPG_CYC..1, so the state lasts exactly IPG_CYC cycles.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef MAC_TX_ARB_IPG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign grant_o = grant_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: doc/mac_tx_arb.md
MAC_TX_ARB -- requirements
Module: mac_tx_arb

Interface
REQ-001 SHALL expose parameter DATA_W, default 16, width of each data beat in bits (legal values 16, 32, 64).
REQ-002 SHALL expose parameter KEEP_W, default DATA_W/8, byte-enable width.
REQ-003 SHALL expose parameter REQ_N, default 2, number of frame sources (2..8).
REQ-004 SHALL expose parameter IPG_CYC, default 12/KEEP_W, idle cycles inserted between frames.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on posedge.
REQ-006 SHALL have port reset, input, 1: reset; one clock, synchronous, active-high.
REQ-007 SHALL have port req_valid_i, input, REQ_N: per-source beat valid.
REQ-008 SHALL have port req_data_i, input, REQ_N*DATA_W: per-source data; source k occupies bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port req_keep_i, input, REQ_N*KEEP_W: per-source byte enables, packed the same way.
REQ-010 SHALL have port req_last_i, input, REQ_N: per-source last beat of frame.
REQ-011 SHALL have port req_ready_o, output, REQ_N: per-source beat accepted.
REQ-012 SHALL have port cancel_i, input, 1: abort the current frame.
REQ-013 SHALL have port valid_o, output, 1: beat to the MAC TX datapath.
REQ-014 SHALL have port data_o, output, DATA_W: data to the MAC TX datapath.
REQ-015 SHALL have port keep_o, output, KEEP_W: byte enables to the MAC TX datapath.
REQ-016 SHALL have port last_o, output, 1: last beat to the MAC TX datapath.
REQ-017 SHALL have port ready_i, input, 1: MAC TX datapath accepts the beat.
REQ-018 SHALL have port grant_o, output, REQ_N: one-hot registered grant.
REQ-019 SHALL have port busy_o, output, 1: high when the FSM is not IDLE.

Function
REQ-020 SHALL implement an FSM with states IDLE, XFER and IPG.
REQ-021 In IDLE with any req_valid_i set, the block SHALL register a one-hot grant to the first valid source at or after rr_ptr (wrapping modulo REQ_N) and go to XFER.
REQ-022 The latency from a source's first req_valid_i to its valid_o SHALL be exactly 1 cycle.
REQ-023 In XFER, valid_o, data_o, keep_o and last_o SHALL be combinational muxes of the granted source.
REQ-024 In XFER, req_ready_o[g] SHALL equal ready_i, and every other req_ready_o bit SHALL be 0.
REQ-025 The beat handshake SHALL be valid&ready; the block SHALL never drop, duplicate or reorder beats.
REQ-026 The grant SHALL hold for the whole frame; other sources' valid SHALL be ignored until frame end.
REQ-027 Frame end is valid_o & ready_i & last_o; on frame end the FSM SHALL go to IPG, grant_o SHALL clear, and rr_ptr SHALL become (g+1) mod REQ_N.
REQ-028 In IPG the block SHALL hold valid_o=0 for IPG_CYC cycles, then go to IDLE.
REQ-029 The IPG counter width SHALL be $clog2(IPG_CYC+1); IPG_CYC=0 SHALL make the transition XFER->IDLE direct.
REQ-030 In IDLE and IPG, valid_o and all req_ready_o SHALL be 0; data_o and keep_o are don't-care.
REQ-031 cancel_i in XFER SHALL clear grant_o, advance rr_ptr past g, and go to IPG that same cycle; the granted source's req_ready_o SHALL be 0 in the cancel cycle.
REQ-032 cancel_i in IDLE or IPG SHALL be ignored.
REQ-033 A request arriving in the same cycle IPG expires SHALL be arbitrated in the following IDLE cycle.
REQ-034 When all sources request continuously, each source SHALL be granted exactly once per REQ_N frames.

Reset
REQ-035 While reset is high, on each posedge the FSM SHALL enter IDLE, rr_ptr SHALL be 0, the IPG counter SHALL be 0, grant_o SHALL be 0, and busy_o SHALL be 0.
REQ-036 A reset asserted mid-frame SHALL force valid_o=0 and req_ready_o=0 from the next cycle; the partial frame is abandoned, not completed.

Configuration
REQ-037 With MAC_TX_ARB_IPG_EN defined, the IPG state and counter SHALL be compiled in as specified.
REQ-038 Without MAC_TX_ARB_IPG_EN, the IPG state and counter SHALL be absent, and frame end or cancel SHALL go directly to IDLE, so back-to-back frames from different sources are separated by exactly one IDLE cycle.

Structure
REQ-039 The state enum and the IPG_CYC default SHALL live in the shared package mac_pkg.
REQ-040 The rotating-priority pick SHALL be one sub-module, rr_arbiter: request vector plus pointer in, one-hot grant out, purely combinational; the FSM and the mux stay in mac_tx_arb.

Verification
REQ-041 Bench SHALL cover this case: source 0 sends 3 beats with last on beat 3 and ready_i=1 -> valid_o rises 1 cycle after req_valid_i[0], 3 beats out, then 6 idle cycles (DATA_W=16, IPG_CYC=6).
REQ-042 Bench SHALL cover this case: sources 0 and 1 request continuously -> frame order 0,1,0,1 and grant_o sequence 01,10,01,10.
REQ-043 Bench SHALL cover this case: ready_i low for 2 cycles mid-frame -> data_o is stable during the stall, req_ready_o[g]=0, and no beat is lost.
REQ-044 Bench SHALL cover this case: cancel_i on beat 2 of a 4-beat frame from source 1 -> grant_o=0 next cycle, IPG entered, and the next grant goes to source 0.
REQ-045 Bench SHALL cover this case: reset pulsed during beat 2 -> valid_o=0, grant_o=0 and busy_o=0 next cycle, then source 0 wins first.
REQ-046 Bench SHALL cover this case: build without MAC_TX_ARB_IPG_EN and send two back-to-back frames -> exactly 1 idle cycle between last_o and the next valid_o.
